// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//   Command handshake and status bundle between a system-side client and the
//   PS/2 host transmitter.
//   master : drives tx_valid/tx_data, observes ready/busy/done/err.
//   slave  : the transmitter itself.
//   Signals:
//     tx_valid   request to send tx_data
//     tx_data    command byte
//     tx_ready   idle, request will be accepted (== !busy)
//     busy       transaction in progress
//     rx_inhibit gate for the companion receiver (== busy)
//     done       one-cycle completion pulse
//     err        status qualified by done: 00 ok, 01 no ack, 10 timeout
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       rx_inhibit;
    logic       done;
    logic [1:0] err;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, busy, rx_inhibit, done, err
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, busy, rx_inhibit, done, err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Requests the bus (clock inhibit, then
//   clock+data low), shifts out 8 data bits LSB first, odd parity and the
//   stop bit on device clock falling edges, then samples the device ack and
//   waits for the bus to go idle. Reports completion/status on done/err.
//
//   Ports:
//     i_clk          system clock, rising edge
//     i_reset        synchronous, active-low reset
//     tx             ps2_host_tx_if.slave (handshake + status)
//     i_ps2_clk_in   raw PS/2 clock pin (asynchronous)
//     i_ps2_data_in  raw PS/2 data pin (asynchronous)
//     o_ps2_clk_oe   1 pulls the PS/2 clock low
//     o_ps2_data_oe  1 pulls the PS/2 data low
//
//   Build option:
//     PS2_TX_FILTER_EN  when defined, the synchronized clock passes through a
//                       4-sample glitch filter before edge detection.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    ps2_host_tx_if.slave  tx,
    input  logic          i_ps2_clk_in,
    input  logic          i_ps2_data_in,
    output logic          o_ps2_clk_oe,
    output logic          o_ps2_data_oe
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int PW     = $clog2(PH_MAX + 1);

    logic [2:0]    r_state;
    logic [PW-1:0] r_ph_cnt;
    logic [3:0]    r_bit_cnt;
    logic [19:0]   r_to_cnt;
    logic [8:0]    r_shift;     // {parity, data}, shifted out LSB first
    logic          r_data_oe;
    logic          r_ack_ok;
    logic          r_done;
    logic [1:0]    r_err;

    logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic r_clk_prev, r_fe;
    logic w_clk_lvl;
    logic w_busy;

    // Synchronizers reset to the idle (released, high) bus level so that
    // leaving reset never fabricates a falling edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= i_ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

`ifdef PS2_TX_FILTER_EN
    logic [2:0] r_clk_hist;
    logic       r_clk_filt;

    // Filtered level moves only when the current and the three previous
    // samples agree; pulses of 3 cycles or fewer never reach it.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_clk_hist <= 3'b111;
            r_clk_filt <= 1'b1;
        end else begin
            r_clk_hist <= {r_clk_hist[1:0], r_clk_s2};
            if (&{r_clk_hist, r_clk_s2})
                r_clk_filt <= 1'b1;
            else if (~|{r_clk_hist, r_clk_s2})
                r_clk_filt <= 1'b0;
        end
    end

    assign w_clk_lvl = r_clk_filt;
`else
    assign w_clk_lvl = r_clk_s2;
`endif

    // Registered falling-edge strobe; the FSM acts on it one cycle later.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_clk_prev <= 1'b1;
            r_fe       <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_lvl;
            r_fe       <= r_clk_prev & ~w_clk_lvl;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_ph_cnt  <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_shift   <= '0;
            r_data_oe <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 2'b00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx.tx_valid) begin
                        r_shift  <= {~^tx.tx_data, tx.tx_data};
                        r_ph_cnt <= '0;
                        r_state  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_ph_cnt == PW'(INHIBIT_CYCLES - 1)) begin
                        r_ph_cnt  <= '0;
                        r_data_oe <= 1'b1;     // start bit
                        r_state   <= S_REQ;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    if (r_ph_cnt == PW'(REQ_CYCLES - 1)) begin
                        r_ph_cnt  <= '0;
                        r_bit_cnt <= '0;
                        r_to_cnt  <= '0;
                        r_state   <= S_SEND;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + 1'b1;
                    end
                end
                default: begin
                    // SEND / ACK / WAIT_IDLE share the timeout, which wins
                    // over any edge seen in the same cycle.
                    if (r_to_cnt == 20'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= S_IDLE;
                        r_data_oe <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 2'b10;
                        r_bit_cnt <= '0;
                        r_to_cnt  <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        case (r_state)
                            S_SEND: begin
                                if (r_fe) begin
                                    r_bit_cnt <= r_bit_cnt + 1'b1;
                                    if (r_bit_cnt == 4'd9) begin
                                        r_data_oe <= 1'b0;   // stop bit
                                        r_state   <= S_ACK;
                                    end else begin
                                        r_data_oe <= ~r_shift[0];
                                        r_shift   <= {1'b0, r_shift[8:1]};
                                    end
                                end
                            end
                            S_ACK: begin
                                if (r_fe) begin
                                    r_bit_cnt <= r_bit_cnt + 1'b1;
                                    r_ack_ok  <= ~r_dat_s2;
                                    r_state   <= S_WAIT_IDLE;
                                end
                            end
                            S_WAIT_IDLE: begin
                                if (r_clk_s2 && r_dat_s2) begin
                                    r_state   <= S_IDLE;
                                    r_done    <= 1'b1;
                                    r_err     <= r_ack_ok ? 2'b00 : 2'b01;
                                    r_bit_cnt <= '0;
                                    r_to_cnt  <= '0;
                                end
                            end
                            default: begin
                                r_state   <= S_IDLE;
                                r_data_oe <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign w_busy        = (r_state != S_IDLE);
    assign tx.busy       = w_busy;
    assign tx.tx_ready   = ~w_busy;
    assign tx.rx_inhibit = w_busy;
    assign tx.done       = r_done;
    assign tx.err        = r_err;
    assign o_ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_REQ);
    assign o_ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    logic clk_oe, data_oe;
    logic bfm_clk_low = 1'b0, bfm_data_low = 1'b0;
    logic clk_line, data_line;
    // Open-drain wired-AND of host and device drivers.
    assign clk_line  = ~(clk_oe | bfm_clk_low);
    assign data_line = ~(data_oe | bfm_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(20), .REQ_CYCLES(5), .TIMEOUT_CYCLES(2000)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .tx            (bus),
        .i_ps2_clk_in  (clk_line),
        .i_ps2_data_in (data_line),
        .o_ps2_clk_oe  (clk_oe),
        .o_ps2_data_oe (data_oe)
    );

    typedef struct {
        logic [1:0] err;
        logic       chk_frame;
        logic [9:0] frame;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [9:0] cap;          // bits seen by the device: data[7:0], parity, stop
    logic chk_busy = 1'b0;
    logic busy_drop = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference frame as the device sees it on the wire: data LSB first,
    // then a parity bit making the total count of ones odd, then stop = 1.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    task automatic push_exp(input logic [1:0] e, input logic chk, input logic [7:0] b);
        exp_t x;
        x.err = e;
        x.chk_frame = chk;
        x.frame = ref_frame(b);
        exp_q.push_back(x);
    endtask

    // Scoreboard monitor: every done pulse consumes one expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            check("done_busy_low", {31'd0, bus.busy}, 32'd0);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_done", "done pulse with nothing outstanding");
            end else begin
                mon_e = exp_q.pop_front();
                check("err", {30'd0, bus.err}, {30'd0, mon_e.err});
                if (mon_e.chk_frame)
                    check("frame", {22'd0, cap}, {22'd0, mon_e.frame});
            end
        end
        if (chk_busy && !bus.busy) busy_drop = 1'b1;
    end

    task automatic send(input logic [7:0] b);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) fail_now("wait_idle", "busy never dropped");
    endtask

    // Device model: waits for the host request, then clocks npulses with a
    // 40-cycle period, sampling data at the end of each low phase. Pulse 10
    // is the ack slot. glitch inserts a 2-cycle low spike in pulse 3's high.
    task automatic bfm_xfer(input logic ack, input int npulses, input logic glitch);
        int n = 0;
        cap = '0;
        while (!(!clk_oe && data_oe) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!(!clk_oe && data_oe)) begin
            fail_now("bfm_request", "host never released clock with data low");
            return;
        end
        repeat (5) @(negedge clk);
        for (int p = 0; p < npulses; p++) begin
            if (p == 10 && ack) bfm_data_low = 1'b1;
            bfm_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            if (p < 10) cap[p] = data_line;
            bfm_clk_low = 1'b0;
            if (glitch && p == 3) begin
                repeat (8) @(negedge clk);
                bfm_clk_low = 1'b1;
                repeat (2) @(negedge clk);
                bfm_clk_low = 1'b0;
                repeat (10) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
        end
        bfm_data_low = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        logic [7:0] b;
        logic ack;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_ready",   {31'd0, bus.tx_ready},   32'd1);
        check("rst_busy",       {31'd0, bus.busy},       32'd0);
        check("rst_rx_inhibit", {31'd0, bus.rx_inhibit}, 32'd0);
        check("rst_done",       {31'd0, bus.done},       32'd0);
        check("rst_err",        {30'd0, bus.err},        32'd0);
        check("rst_clk_oe",     {31'd0, clk_oe},         32'd0);
        check("rst_data_oe",    {31'd0, data_oe},        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0xF4 with ack; busy must stay high for the whole transfer.
        push_exp(2'b00, 1'b1, 8'hF4);
        send(8'hF4);
        check("busy_after_accept",   {31'd0, bus.busy},       32'd1);
        check("rx_inhibit_after_acc",{31'd0, bus.rx_inhibit}, 32'd1);
        check("clk_oe_after_accept", {31'd0, clk_oe},         32'd1);
        busy_drop = 1'b0;
        chk_busy  = 1'b1;
        bfm_xfer(1'b1, 11, 1'b0);
        chk_busy  = 1'b0;
        check("busy_throughout", {31'd0, busy_drop}, 32'd0);
        wait_idle();

        // 0xED with ack; measure inhibit and request phase lengths.
        push_exp(2'b00, 1'b1, 8'hED);
        send(8'hED);
        n = 0;
        while (clk_oe && !data_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("inhibit_cycles", n, 32'd20);
        n = 0;
        while (clk_oe && data_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_cycles", n, 32'd5);
        bfm_xfer(1'b1, 11, 1'b0);
        wait_idle();

        // 0xFF, device leaves data high in the ack slot.
        push_exp(2'b01, 1'b1, 8'hFF);
        send(8'hFF);
        bfm_xfer(1'b0, 11, 1'b0);
        wait_idle();
        check("noack_clk_oe",  {31'd0, clk_oe},  32'd0);
        check("noack_data_oe", {31'd0, data_oe}, 32'd0);

        // 0x00, device never clocks: timeout from clock release.
        push_exp(2'b10, 1'b0, 8'h00);
        send(8'h00);
        n = 0;
        while (clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!bus.done && n < 2100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles",  n, 32'd2000);
        check("timeout_clk_oe",  {31'd0, clk_oe},  32'd0);
        check("timeout_data_oe", {31'd0, data_oe}, 32'd0);
        wait_idle();

        // Abort after 4 data bits: reset, no done pulse, status cleared.
        send(8'hF4);
        bfm_xfer(1'b1, 4, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy",    {31'd0, bus.busy}, 32'd0);
        check("abort_clk_oe",  {31'd0, clk_oe},   32'd0);
        check("abort_data_oe", {31'd0, data_oe},  32'd0);
        check("abort_err",     {30'd0, bus.err},  32'd0);
        repeat (60) @(negedge clk);

        // Fresh 0xF4 with a stray request in the middle that must be dropped.
        push_exp(2'b00, 1'b1, 8'hF4);
        send(8'hF4);
        fork
            bfm_xfer(1'b1, 11, 1'b0);
            begin
                repeat (150) @(negedge clk);
                bus.tx_data  = 8'h5A;
                bus.tx_valid = 1'b1;
                @(negedge clk);
                bus.tx_valid = 1'b0;
            end
        join
        wait_idle();
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (bus.busy) seen = 1'b1;
        end
        check("no_queued_request", {31'd0, seen}, 32'd0);

        // Random bytes and ack behaviour, back to back.
        for (int i = 0; i < 6; i++) begin
            b   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            push_exp(ack ? 2'b00 : 2'b01, 1'b1, b);
            send(b);
            check("rand_accept", {31'd0, bus.busy}, 32'd1);
            bfm_xfer(ack, 11, 1'b0);
            wait_idle();
        end

`ifdef PS2_TX_FILTER_EN
        // Short clock glitch must not advance the bit sequence.
        push_exp(2'b00, 1'b1, 8'hF4);
        send(8'hF4);
        bfm_xfer(1'b1, 11, 1'b1);
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
